// File: rtl/wb_stage_pkg.sv
// Shared types for the write-back stage: register-file command
// encodings, FSM states and the record filter helper.
package wb_stage_pkg;

   typedef enum logic [1:0] {
      RF_NOP   = 2'b00,
      RF_READ  = 2'b01,
      RF_WRITE = 2'b10
   } rf_cmd_e;

   typedef enum logic {
      WB_IDLE = 1'b0,
      WB_WAIT = 1'b1
   } wb_state_e;

   function automatic logic wb_writes(
      input logic       we,
      input logic [4:0] rd
   );
      return we && (rd != 5'd0);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order record queue for wb_stage. With WB_FORWARD_EN the entries
// are also exposed oldest-first together with a valid mask.
module wb_fifo #(
   parameter int LEN   = 32,
   parameter int DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  logic [4:0]     push_rd,
   input  logic [LEN-1:0] push_data,
   input  logic           pop,
   output logic [4:0]     head_rd,
   output logic [LEN-1:0] head_data,
   output logic           full,
   output logic           empty
`ifdef WB_FORWARD_EN
   ,
   output logic [DEPTH-1:0][4:0]     ent_rd,
   output logic [DEPTH-1:0][LEN-1:0] ent_data,
   output logic [DEPTH-1:0]          ent_vld
`endif
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [IW-1:0] wi, ri;

   logic [DEPTH-1:0][4:0]     rd_mem_q;
   logic [DEPTH-1:0][LEN-1:0] dat_mem_q;

   assign wi = wr_q[IW-1:0];
   assign ri = rd_q[IW-1:0];

   // Extra pointer bit tells a full queue from an empty one.
   assign empty = (wr_q == rd_q);
   assign full  = (wi == ri) && (wr_q[IW] != rd_q[IW]);

   assign head_rd   = rd_mem_q[ri];
   assign head_data = dat_mem_q[ri];

   assign wr_d = wr_q + PW'(push);
   assign rd_d = rd_q + PW'(pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q      <= '0;
         rd_q      <= '0;
         rd_mem_q  <= '0;
         dat_mem_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (push) begin
            rd_mem_q[wi]  <= push_rd;
            dat_mem_q[wi] <= push_data;
         end
      end
   end

`ifdef WB_FORWARD_EN
   logic [PW-1:0] cnt;

   assign cnt = wr_q - rd_q;

   always_comb begin
      ent_rd   = '0;
      ent_data = '0;
      ent_vld  = '0;
      for (int a = 0; a < DEPTH; a++) begin
         ent_rd[a]   = rd_mem_q[ri + IW'(a)];
         ent_data[a] = dat_mem_q[ri + IW'(a)];
         ent_vld[a]  = PW'(a) < cnt;
      end
   end
`endif

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: queues records and drains them to the register
// file one write at a time. Define WB_FORWARD_EN for the bypass port.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int LEN   = 32,
   parameter int DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rdy_in,
   input  logic           wb_valid,
   input  logic [4:0]     wb_rd,
   input  logic [LEN-1:0] wb_data,
   input  logic           wb_reg_write,
   output logic           wb_ready,
   output logic [1:0]     rf_signal,
   output logic [4:0]     rf_rd,
   output logic [LEN-1:0] rf_data,
   input  logic           rf_vis_finished,
   output logic           wb_busy,
   output logic [31:0]    retire_cnt
`ifdef WB_FORWARD_EN
   ,
   input  logic [4:0]     fwd_rs,
   output logic           fwd_hit,
   output logic [LEN-1:0] fwd_data
`endif
);

   logic           full, empty;
   logic           accept, push, filt, done;
   logic [4:0]     head_rd;
   logic [LEN-1:0] head_data;

   wb_state_e      state_q, state_d;
   rf_cmd_e        sig_q, sig_d;
   logic [4:0]     rd_q, rd_d;
   logic [LEN-1:0] data_q, data_d;
   logic [31:0]    cnt_q, cnt_d;

`ifdef WB_FORWARD_EN
   logic [DEPTH-1:0][4:0]     ent_rd;
   logic [DEPTH-1:0][LEN-1:0] ent_data;
   logic [DEPTH-1:0]          ent_vld;
`endif

   assign wb_ready = !full && rdy_in;
   assign accept   = wb_valid && wb_ready;
   assign push     = accept && wb_writes(wb_reg_write, wb_rd);
   assign filt     = accept && !push;
   assign done     = rdy_in && (state_q == WB_WAIT) && rf_vis_finished;

   wb_fifo #(
      .LEN   (LEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_rd   (wb_rd),
      .push_data (wb_data),
      .pop       (done),
      .head_rd   (head_rd),
      .head_data (head_data),
      .full      (full),
      .empty     (empty)
`ifdef WB_FORWARD_EN
      ,
      .ent_rd    (ent_rd),
      .ent_data  (ent_data),
      .ent_vld   (ent_vld)
`endif
   );

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      rd_d    = rd_q;
      data_d  = data_q;
      cnt_d   = cnt_q + 32'(filt) + 32'(done);
      if (rdy_in) begin
         unique case (state_q)
            WB_IDLE: begin
               if (!empty) begin
                  rd_d    = head_rd;
                  data_d  = head_data;
                  sig_d   = RF_WRITE;
                  state_d = WB_WAIT;
               end
            end
            WB_WAIT: begin
               if (rf_vis_finished) begin
                  sig_d   = RF_NOP;
                  state_d = WB_IDLE;
               end
            end
            default: state_d = WB_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= WB_IDLE;
         sig_q   <= RF_NOP;
         rd_q    <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rf_signal  = sig_q;
   assign rf_rd      = rd_q;
   assign rf_data    = data_q;
   assign retire_cnt = cnt_q;
   assign wb_busy    = !empty || (state_q == WB_WAIT);

`ifdef WB_FORWARD_EN
   // Walk oldest to youngest so the youngest match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int a = 0; a < DEPTH; a++) begin
         if (ent_vld[a] && ent_rd[a] == fwd_rs && fwd_rs != 5'd0) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_data[a];
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writes are queued at accept
// and checked by a monitor when the register-file write appears.
module tb_wb_stage;
   import wb_stage_pkg::*;

   localparam int LEN   = 32;
   localparam int DEPTH = 2;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           rdy_in = 1'b1;
   logic           wb_valid = 1'b0;
   logic [4:0]     wb_rd = '0;
   logic [LEN-1:0] wb_data = '0;
   logic           wb_reg_write = 1'b0;
   logic           wb_ready;
   logic [1:0]     rf_signal;
   logic [4:0]     rf_rd;
   logic [LEN-1:0] rf_data;
   logic           rf_vis_finished = 1'b0;
   logic           wb_busy;
   logic [31:0]    retire_cnt;
`ifdef WB_FORWARD_EN
   logic [4:0]     fwd_rs = '0;
   logic           fwd_hit;
   logic [LEN-1:0] fwd_data;
`endif

   int   vec = 0;
   int   mis = 0;
   exp_t sb[$];
   exp_t cur;
   logic [1:0] prev_sig = RF_NOP;
   logic auto_fin = 1'b0;
   logic man_fin  = 1'b0;

   wb_stage #(
      .LEN   (LEN),
      .DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .rdy_in          (rdy_in),
      .wb_valid        (wb_valid),
      .wb_rd           (wb_rd),
      .wb_data         (wb_data),
      .wb_reg_write    (wb_reg_write),
      .wb_ready        (wb_ready),
      .rf_signal       (rf_signal),
      .rf_rd           (rf_rd),
      .rf_data         (rf_data),
      .rf_vis_finished (rf_vis_finished),
      .wb_busy         (wb_busy),
      .retire_cnt      (retire_cnt)
`ifdef WB_FORWARD_EN
      ,
      .fwd_rs          (fwd_rs),
      .fwd_hit         (fwd_hit),
      .fwd_data        (fwd_data)
`endif
   );

   always #5 clk = ~clk;

   function automatic void chk(
      input string       nm,
      input logic [63:0] act,
      input logic [63:0] exp
   );
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Register-file model: acknowledge every write after one cycle,
   // or follow the manual flag.
   always @(negedge clk)
      rf_vis_finished = auto_fin ? (rf_signal == RF_WRITE) : man_fin;

   always @(negedge clk) begin
      if (!rst) begin
         prev_sig = RF_NOP;
      end else begin
         if (rf_signal != RF_NOP && rf_signal != RF_WRITE)
            chk("rf_cmd", 64'(rf_signal), 64'(RF_WRITE));
         if (rf_signal == RF_WRITE && prev_sig == RF_NOP) begin
            if (sb.size() == 0) begin
               vec++;
               mis++;
               $display("FAIL unexpected_write: got rd %0d expected none",
                        rf_rd);
            end else begin
               cur = sb.pop_front();
               chk("wr_rd", 64'(rf_rd), 64'(cur.rd));
               chk("wr_data", 64'(rf_data), 64'(cur.data));
            end
         end else if (rf_signal == RF_WRITE) begin
            chk("hold_rd", 64'(rf_rd), 64'(cur.rd));
            chk("hold_data", 64'(rf_data), 64'(cur.data));
         end
         prev_sig = rf_signal;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(
      input logic [4:0]  rd,
      input logic [31:0] d,
      input logic        we
   );
      int n = 0;
      wb_valid     = 1'b1;
      wb_rd        = rd;
      wb_data      = d;
      wb_reg_write = we;
      while (!wb_ready && n < 50) begin
         tick();
         n++;
      end
      chk("push_ready", 64'(wb_ready), 64'd1);
      if (wb_ready && we && rd != 5'd0)
         sb.push_back('{rd, d});
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (wb_busy && n < 100) begin
         tick();
         n++;
      end
      chk("idle_timeout", 64'(wb_busy), 64'd0);
   endtask

   initial begin
      #12;
      chk("rst_sig", 64'(rf_signal), 64'(RF_NOP));
      chk("rst_rd", 64'(rf_rd), 64'd0);
      chk("rst_data", 64'(rf_data), 64'd0);
      chk("rst_busy", 64'(wb_busy), 64'd0);
      chk("rst_cnt", 64'(retire_cnt), 64'd0);
      rst = 1'b1;
      tick();
      chk("rst_ready", 64'(wb_ready), 64'd1);

      // single write
      auto_fin = 1'b1;
      push(5'd5, 32'hDEADBEEF, 1'b1);
      chk("t1_busy", 64'(wb_busy), 64'd1);
      tick();
      chk("t1_write", 64'(rf_signal), 64'(RF_WRITE));
      wait_idle();
      chk("t1_cnt", 64'(retire_cnt), 64'd1);
      chk("t1_nop", 64'(rf_signal), 64'(RF_NOP));

      // filtered records
      push(5'd0, 32'h11111111, 1'b1);
      push(5'd3, 32'h22222222, 1'b0);
      tick();
      chk("t2_busy", 64'(wb_busy), 64'd0);
      chk("t2_cnt", 64'(retire_cnt), 64'd3);

      // back-pressure on a full queue
      auto_fin = 1'b0;
      push(5'd1, 32'hA0A0A0A0, 1'b1);
      push(5'd2, 32'hB0B0B0B0, 1'b1);
      chk("t3_full", 64'(wb_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_hold_ready", 64'(wb_ready), 64'd0);
         chk("t3_hold_rd", 64'(rf_rd), 64'd1);
      end
      auto_fin = 1'b1;
      push(5'd3, 32'hC0C0C0C0, 1'b1);
      wait_idle();
      chk("t3_cnt", 64'(retire_cnt), 64'd6);

      // same rd twice
      push(5'd7, 32'd1, 1'b1);
      push(5'd7, 32'd2, 1'b1);
`ifdef WB_FORWARD_EN
      fwd_rs = 5'd7;
      #1;
      chk("fwd_hit", 64'(fwd_hit), 64'd1);
      chk("fwd_data", 64'(fwd_data), 64'd2);
      fwd_rs = 5'd0;
      #1;
      chk("fwd_x0", 64'(fwd_hit), 64'd0);
`endif
      wait_idle();
      chk("t4_cnt", 64'(retire_cnt), 64'd8);

      // filtered accept with write completion
      auto_fin = 1'b0;
      man_fin  = 1'b0;
      push(5'd4, 32'h44, 1'b1);
      tick();
      chk("t5_write", 64'(rf_signal), 64'(RF_WRITE));
      chk("t5_pre", 64'(retire_cnt), 64'd8);
      wb_valid     = 1'b1;
      wb_rd        = 5'd0;
      wb_reg_write = 1'b1;
      man_fin      = 1'b1;
      tick();
      wb_valid = 1'b0;
      man_fin  = 1'b0;
      chk("t5_cnt", 64'(retire_cnt), 64'd10);
      chk("t5_nop", 64'(rf_signal), 64'(RF_NOP));

      // reset mid-write
      push(5'd6, 32'h66, 1'b1);
      push(5'd8, 32'h88, 1'b1);
      tick();
      chk("t6_write", 64'(rf_signal), 64'(RF_WRITE));
      #2;
      rst = 1'b0;
      #1;
      sb.delete();
      chk("t6_sig", 64'(rf_signal), 64'(RF_NOP));
      chk("t6_busy", 64'(wb_busy), 64'd0);
      chk("t6_cnt", 64'(retire_cnt), 64'd0);
      tick();
      rst = 1'b1;
      tick();
      tick();
      chk("t6_after", 64'(rf_signal), 64'(RF_NOP));
      chk("t6_empty", 64'(wb_busy), 64'd0);

      // freeze
      push(5'd9, 32'h99, 1'b1);
      tick();
      rdy_in       = 1'b0;
      man_fin      = 1'b1;
      wb_valid     = 1'b1;
      wb_rd        = 5'd10;
      wb_data      = 32'hAA;
      wb_reg_write = 1'b1;
      #1;
      chk("t7_ready", 64'(wb_ready), 64'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t7_sig", 64'(rf_signal), 64'(RF_WRITE));
         chk("t7_rd", 64'(rf_rd), 64'd9);
         chk("t7_data", 64'(rf_data), 64'h99);
         chk("t7_cnt", 64'(retire_cnt), 64'd0);
         chk("t7_busy", 64'(wb_busy), 64'd1);
      end
      wb_valid = 1'b0;
      rdy_in   = 1'b1;
      tick();
      man_fin  = 1'b0;
      auto_fin = 1'b1;
      wait_idle();
      chk("t7_done", 64'(retire_cnt), 64'd1);
      tick();
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage between the memory stage and the register file. Accepts completed-instruction records (rd, result, write-enable) via valid/ready into a small in-order queue. Drains the queue one record at a time using the register file's 2-bit command interface (RF_NOP/RF_READ/RF_WRITE), waiting on rf_vis_finished per write. Filters non-writing and x0 records and keeps a retired-instruction count.

Parameters:
LEN, 32, data width of a register / result
DEPTH, 2, queue entries; power of 2, >= 2

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset, asynchronous, active-low
rdy_in  in  1  global enable; low = freeze all state
wb_valid  in  1  upstream record valid
wb_rd  in  5  destination register index
wb_data  in  LEN  result value
wb_reg_write  in  1  record writes rd
wb_ready  out  1  stage can accept a record this cycle
rf_signal  out  2  command to register file (RF_NOP / RF_WRITE only)
rf_rd  out  5  write index to register file
rf_data  out  LEN  write data to register file
rf_vis_finished  in  1  register file completion flag
wb_busy  out  1  queue non-empty or write in flight
retire_cnt  out  32  records retired since reset

Behaviour:
- Reset (rst=0, async): state IDLE; queue pointers 0; rf_signal=RF_NOP, rf_rd=0, rf_data=0, wb_busy=0, retire_cnt=0. Mid-write reset drops queued records and the in-flight write; rf_signal returns to RF_NOP immediately.
- wb_ready = !full && rdy_in (combinational). Accept = wb_valid && wb_ready at posedge.
- Filter: an accepted record with wb_reg_write=0 or wb_rd=0 is not enqueued; retire_cnt +1 that cycle.
- Queue: FIFO with pointers of log2(DEPTH)+1 bits; full when indices equal and wrap bits differ, empty when pointers equal. Push and pop in the same cycle are legal when not full; count unchanged.
- FSM, registered outputs:
  IDLE: queue non-empty -> load head rd/data into rf_rd/rf_data, rf_signal=RF_WRITE, go WAIT.
  WAIT: hold RF_WRITE, rf_rd, rf_data stable; on posedge with rf_vis_finished=1 -> pop head, rf_signal=RF_NOP, retire_cnt +1, go IDLE.
  Sustained throughput is 1 write per 2 cycles minimum; at least one RF_NOP cycle between writes.
- Filtered retire and write completion in the same cycle: retire_cnt +2. retire_cnt wraps modulo 2^32.
- Writes reach the register file strictly in acceptance order; repeated rd writes in order, last wins.
- wb_busy = !empty || state==WAIT.
- rdy_in=0: no pointer, FSM, counter, or output change; rf_vis_finished ignored.
- rf_vis_finished in IDLE is ignored.

Optional Feature:
WB_FORWARD_EN: adds ports fwd_rs (in, 5), fwd_hit (out, 1), fwd_data (out, LEN). Combinational lookup across valid queue entries, including the in-flight head. The youngest entry with rd==fwd_rs is selected. fwd_rs=0 never hits. Without the macro these ports are absent, and decode must stall while wb_busy=1 and a hazard exists.

Decomposition:
- Shared defines file: RF_NOP/RF_READ/RF_WRITE encodings (existing); WB_IDLE/WB_WAIT state constants.
- One sub-module, wb_fifo: storage, pointers, full/empty, parameterised by LEN and DEPTH. Exposes the entry array and valid mask for forwarding.

Test Plan:
- Reset then one record rd=5, data=0xDEADBEEF, reg_write=1 -> next cycle rf_signal=RF_WRITE, rf_rd=5; finished=1 -> RF_NOP, retire_cnt=1, wb_busy=0.
- Records rd=0 and reg_write=0 -> rf_signal stays RF_NOP throughout, retire_cnt=2.
- Hold rf_vis_finished=0, push 3 writes with DEPTH=2 -> wb_ready=0 after 2 accepted. Release -> writes issued in order, third accepted once space frees.
- Push rd=7 data=1 then rd=7 data=2 -> two RF_WRITEs to 7 in that order. With WB_FORWARD_EN, fwd_rs=7 gives fwd_hit=1, fwd_data=2.
- Filtered accept coincides with write completion -> retire_cnt increments by 2.
- rst low during WAIT -> rf_signal=RF_NOP immediately, wb_busy=0, queue empty; rdy_in=0 for 5 cycles -> all outputs frozen.
